// File: rtl/eth_rx_stat_counters.sv
// rtl/eth_rx_stat_counters.sv - per-port RX event counters with snapshot bank, indirect read and masked error IRQ
//
// Purpose:
//   NETH x N_EVT live event counters (CNT_W bits each) fed by 1-cycle strobes.
//   A snapshot strobe copies every live counter into a shadow bank in one
//   edge, optionally restarting the live counters.  Software reads the shadow
//   bank through a select/data pair.  Per-event-type pending bits drive a
//   masked, registered interrupt.
//
// Ports:
//   clk          core clock
//   rst_n        asynchronous active-low reset
//   evt_i        event strobes, bit p*N_EVT+e = event type e on port p
//   snap_i       snapshot strobe (shadow <= live)
//   clr_all_i    clear live, shadow, overflow and pending state (highest priority)
//   rd_i         read strobe
//   rd_addr_i    counter index p*N_EVT+e
//   rd_data_o    shadow value of the addressed counter (1-cycle latency, held)
//   rd_val_o     rd_data_o valid pulse
//   ovf_o        sticky per-counter overflow flags
//   irq_mask_i   per-event-type interrupt enable
//   irq_o        pending-error interrupt

module eth_rx_stat_counters #(
   parameter int NETH        = 1,
   parameter int N_EVT       = 6,
   parameter int CNT_W       = 32,
   parameter int SATURATE    = 1,
   parameter int CLR_ON_SNAP = 1,
   parameter int N_CNT       = NETH * N_EVT,
   parameter int ADDR_W      = (N_CNT > 1) ? $clog2(N_CNT) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [N_CNT-1:0]  evt_i,
   input  logic              snap_i,
   input  logic              clr_all_i,
   input  logic              rd_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   output logic [CNT_W-1:0]  rd_data_o,
   output logic              rd_val_o,
   output logic [N_CNT-1:0]  ovf_o,
   input  logic [N_EVT-1:0]  irq_mask_i,
   output logic              irq_o
);

   localparam logic [CNT_W-1:0]  CNT_MAX = '1;
   localparam logic [ADDR_W:0]   N_CNT_L = (ADDR_W + 1)'(N_CNT);
   localparam bit                SAT_EN  = (SATURATE != 0);
   localparam bit                CLR_EN  = (CLR_ON_SNAP != 0);

   logic [CNT_W-1:0] live_q   [N_CNT];
   logic [CNT_W-1:0] live_d   [N_CNT];
   logic [CNT_W-1:0] shadow_q [N_CNT];
   logic [CNT_W-1:0] shadow_d [N_CNT];
   logic [N_CNT-1:0] ovf_q, ovf_d;
   logic [N_EVT-1:0] pend_q, pend_d;
   logic             irq_q, irq_d;
   logic [CNT_W-1:0] rd_data_q, rd_data_d;
   logic             rd_val_q, rd_val_d;
   logic             snap_clr;

   // A clearing snapshot restarts live counters and flags from zero, but the
   // same-cycle event is still applied on top so it is never lost.
   assign snap_clr = snap_i & CLR_EN;

   always_comb begin
      ovf_d  = snap_clr ? '0 : ovf_q;
      pend_d = snap_clr ? '0 : pend_q;
      for (int i = 0; i < N_CNT; i++) begin
         shadow_d[i] = snap_i ? live_q[i] : shadow_q[i];
         live_d[i]   = snap_clr ? '0 : live_q[i];
         if (evt_i[i]) begin
            pend_d[i % N_EVT] = 1'b1;
            if (live_d[i] == CNT_MAX) begin
               ovf_d[i]  = 1'b1;
               live_d[i] = SAT_EN ? CNT_MAX : '0;
            end else begin
               live_d[i] = live_d[i] + CNT_W'(1);
            end
         end
      end

      if (clr_all_i) begin
         ovf_d  = '0;
         pend_d = '0;
         for (int i = 0; i < N_CNT; i++) begin
            live_d[i]   = '0;
            shadow_d[i] = '0;
         end
      end

      irq_d = |(pend_d & irq_mask_i);

      // Reads sample the shadow bank before this edge's snapshot/clear.
      rd_val_d  = rd_i;
      rd_data_d = rd_data_q;
      if (rd_i) begin
         if ({1'b0, rd_addr_i} < N_CNT_L) begin
            rd_data_d = shadow_q[rd_addr_i];
         end else begin
            rd_data_d = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_CNT; i++) begin
            live_q[i]   <= '0;
            shadow_q[i] <= '0;
         end
         ovf_q     <= '0;
         pend_q    <= '0;
         irq_q     <= 1'b0;
         rd_data_q <= '0;
         rd_val_q  <= 1'b0;
      end else begin
         live_q    <= live_d;
         shadow_q  <= shadow_d;
         ovf_q     <= ovf_d;
         pend_q    <= pend_d;
         irq_q     <= irq_d;
         rd_data_q <= rd_data_d;
         rd_val_q  <= rd_val_d;
      end
   end

   assign rd_data_o = rd_data_q;
   assign rd_val_o  = rd_val_q;
   assign ovf_o     = ovf_q;
   assign irq_o     = irq_q;

endmodule

// File: doc/eth_rx_stat_counters.md
Name: eth_rx_stat_counters

Overview:
- Parametrised successor to the fixed `rx_queue_status_t` counter set: NETH ports × N_EVT event types, each a CNT_W counter.
- Sits beside the RX packet queues and is fed by 1-cycle event strobes.
- Counters are captured atomically into a shadow bank by a snapshot strobe, optionally clearing the live counters at the same moment.
- Software reads the shadow bank indirectly (select/data), and a masked pending-error interrupt is produced for the IRQ status logic.

Parameters:
- NETH, 1, number of Ethernet ports.
- N_EVT, 6, event types per port. Index 0 frm_size_err, 1 rx_queue_ovf, 2 rx_desc_ovf, 3 line_error, 4 crc_error, 5 packets_received.
- CNT_W, 32, width of every counter (≥2).
- SATURATE, 1, 1 = counter holds at max; 0 = counter wraps to 0.
- CLR_ON_SNAP, 1, 1 = snapshot also clears live counters.
- N_CNT, NETH*N_EVT, derived: total counter count.
- ADDR_W, max(1,$clog2(N_CNT)), derived: read address width.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- evt_i  in  N_CNT  event strobes; bit p*N_EVT+e = event e on port p; 1 cycle = 1 count
- snap_i  in  1  1-cycle snapshot strobe
- clr_all_i  in  1  1-cycle clear of live counters, shadow, ovf and pending flags
- rd_i  in  1  read strobe
- rd_addr_i  in  ADDR_W  counter index p*N_EVT+e
- rd_data_o  out  CNT_W  shadow value of the addressed counter
- rd_val_o  out  1  rd_data_o valid (1 cycle)
- ovf_o  out  N_CNT  sticky per-counter overflow flag
- irq_mask_i  in  N_EVT  per-event-type interrupt enable
- irq_o  out  1  pending-error interrupt

Behaviour:
- Reset (rst_n=0, asynchronous):
  - live and shadow counters = 0;
  - ovf_o = 0, err_pend = 0, irq_o = 0;
  - rd_data_o = 0, rd_val_o = 0.
  - Reset mid-operation discards all counts immediately, with no partial update.
- Counting: evt_i bit high at edge t gives live counter +1, visible in the live value after t. Bits are independent, so all N_CNT counters may increment in the same cycle.
- Max value = 2^CNT_W-1. An event while live = max:
  - sets ovf_o[i];
  - SATURATE=1: counter stays at max;
  - SATURATE=0: counter becomes 0.
- Snapshot (snap_i at edge t):
  - shadow[i] <= live[i], using the pre-increment value; all counters are captured atomically in the same edge.
  - If CLR_ON_SNAP=1: live[i] <= evt_i[i] ? 1 : 0, so a same-cycle event is never lost.
  - If CLR_ON_SNAP=1: ovf_o and err_pend are cleared, unless set again in the same cycle by an event at max / a new error event.
  - If CLR_ON_SNAP=0: live counters keep counting; ovf_o and err_pend are unaffected.
- clr_all_i has priority over snap_i and evt_i in the same cycle: everything becomes 0, and same-cycle events are dropped.
- Read:
  - rd_i at edge t gives rd_val_o=1 and rd_data_o=shadow[rd_addr_i] after t (latency 1). rd_val_o=0 otherwise; rd_data_o holds its last value.
  - Back-to-back reads are allowed every cycle.
  - rd_addr_i ≥ N_CNT returns 0 with rd_val_o=1.
  - Read and snap in the same cycle returns the old shadow value.
  - Reads never modify counters.
- Interrupt:
  - err_pend[e] (N_EVT bits) is set when any port's evt_i for type e fires.
  - irq_o is a register updated every cycle: irq_o <= |(next_err_pend & irq_mask_i). It therefore rises the edge after the first event and falls the edge after a clearing snapshot, clr_all, or mask removal.
  - packets_received (e=5) is counted like the others; software masks it out if it is not wanted.
- Width rules: all arithmetic is unsigned CNT_W; there is no carry out other than ovf_o.

Test Plan:
- Reset check: NETH=2, pulse evt_i[0] 5 times, assert rst_n=0 asynchronously mid-clock. Required: all outputs 0 immediately. After release, snap then read addr 0 → rd_data_o=0, rd_val_o=1 one cycle after rd_i.
- Basic count, snapshot and read: NETH=2, evt_i[4] (crc, port 0) ×3 and evt_i[10] (crc, port 1) ×7, then snap. Required: reads of addr 4 → 3 and addr 10 → 7. With CLR_ON_SNAP=1, a second snap followed by reads → both 0.
- Simultaneous snap and event: live[4]=3, snap_i and evt_i[4] in the same cycle. Required: shadow=3, live=1 (CLR_ON_SNAP=1). Next snap → shadow 1.
- Saturate vs wrap: CNT_W=4, 17 events on counter 0.
  - SATURATE=1: shadow=15, ovf_o[0]=1.
  - SATURATE=0: shadow=1 (count 16 wraps to 0, count 17 gives 1), ovf_o[0]=1.
  - clr_all_i: ovf_o[0]=0.
- IRQ masking: irq_mask_i=6'b010000 with evt_i[0] only → irq_o stays 0. Then evt_i[4] → irq_o=1 on the next edge. Then snap (CLR_ON_SNAP=1) → irq_o=0 on the following edge. Then clr_all_i together with evt_i[4] → irq_o=0 and counter 0.
- Out-of-range read: NETH=1 (N_CNT=6, ADDR_W=3), rd_addr_i=7 → rd_data_o=0, rd_val_o=1. Back-to-back reads of addr 0,1,2 → three consecutive rd_val_o pulses returning the matching shadow values.
